// File: rtl/fmdll_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fmdll_div_sequencer
// Brief    : N*M frame sequencer for the FMDLL select logic. Produces the
//            DIV_N / DIV_M strobes, M_counter and active M, applies new N/M
//            only at frame boundaries followed by a settle gap, and reports
//            lock after a run of clean frames.
// Revision : 1.0 - initial release
// ============================================================================
module fmdll_div_sequencer #(
  parameter int N_W         = 4,
  parameter int M_W         = 2,
  parameter int DEF_N       = 4,
  parameter int DEF_M       = 2,
  parameter int SETTLE_CYC  = 2,
  parameter int LOCK_FRAMES = 16
) (
  input  logic           clk_out,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           cfg_valid,
  input  logic [N_W-1:0] cfg_n,
  input  logic [M_W-1:0] cfg_m,
  output logic           cfg_ready,
  output logic           cfg_err,
  output logic           DIV_N,
  output logic           DIV_M,
  output logic [M_W-1:0] M,
  output logic [M_W-1:0] M_counter,
  output logic           lock,
  output logic           busy
);

  localparam int c_SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int c_LCK_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE_CYC - 1);
  localparam logic [c_LCK_W-1:0] c_LCK_MAX  = c_LCK_W'(LOCK_FRAMES);
  localparam logic [N_W-1:0]     c_N_MIN    = N_W'(2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t             r_state;
  logic [N_W-1:0]     r_n_cnt;
  logic [M_W-1:0]     r_m_cnt;
  logic [N_W-1:0]     r_n;
  logic [M_W-1:0]     r_m;
  logic               r_pend;
  logic [N_W-1:0]     r_pend_n;
  logic [M_W-1:0]     r_pend_m;
  logic [c_SET_W-1:0] r_set_cnt;
  logic [c_LCK_W-1:0] r_lock_cnt;
  logic               r_div_n;
  logic               r_div_m;
  logic               r_lock;
  logic               r_busy;
  logic               r_ready;
  logic               r_cfg_err;

  logic               w_hs;
  logic               w_legal;
  logic               w_n_last;
  logic               w_m_last;
  state_t             w_nxt_state;
  logic [N_W-1:0]     w_nxt_n_cnt;
  logic [M_W-1:0]     w_nxt_m_cnt;
  logic [c_SET_W-1:0] w_nxt_set;
  logic               w_apply;
  logic [N_W-1:0]     w_apply_n;
  logic [M_W-1:0]     w_apply_m;
  logic               w_nxt_pend;
  logic [N_W-1:0]     w_nxt_pend_n;
  logic [M_W-1:0]     w_nxt_pend_m;
  logic [N_W-1:0]     w_nxt_n;
  logic [M_W-1:0]     w_nxt_m;
  logic               w_nxt_n_end;
  logic               w_nxt_div_m;
  logic [c_LCK_W-1:0] w_nxt_lock_cnt;

  assign w_hs     = cfg_valid && r_ready;
  assign w_legal  = (cfg_n >= c_N_MIN) && (cfg_m != '0);
  assign w_n_last = (r_n_cnt == r_n - 1'b1);
  assign w_m_last = (r_m_cnt == r_m - 1'b1);

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_n_cnt  = r_n_cnt;
    w_nxt_m_cnt  = r_m_cnt;
    w_nxt_set    = r_set_cnt;
    w_apply      = 1'b0;
    w_apply_n    = r_pend_n;
    w_apply_m    = r_pend_m;
    w_nxt_pend   = r_pend;
    w_nxt_pend_n = r_pend_n;
    w_nxt_pend_m = r_pend_m;

    case (r_state)
      S_IDLE: begin
        w_nxt_n_cnt = '0;
        w_nxt_m_cnt = '0;
        // A config captured on the way out of RUN is honoured here first.
        if (r_pend) begin
          w_apply     = 1'b1;
          w_nxt_pend  = 1'b0;
          w_nxt_state = S_SETTLE;
          w_nxt_set   = '0;
        end else if (w_hs && w_legal) begin
          w_apply     = 1'b1;
          w_apply_n   = cfg_n;
          w_apply_m   = cfg_m;
          w_nxt_state = S_SETTLE;
          w_nxt_set   = '0;
        end else if (enable) begin
          w_nxt_state = S_RUN;
        end
      end

      S_RUN: begin
        if (w_n_last) begin
          w_nxt_n_cnt = '0;
          if (w_m_last) begin
            w_nxt_m_cnt = '0;
            if (r_pend) begin
              w_apply     = 1'b1;
              w_nxt_pend  = 1'b0;
              w_nxt_state = S_SETTLE;
              w_nxt_set   = '0;
            end else if (!enable) begin
              w_nxt_state = S_IDLE;
            end
          end else begin
            w_nxt_m_cnt = r_m_cnt + 1'b1;
          end
        end else begin
          w_nxt_n_cnt = r_n_cnt + 1'b1;
        end
        // w_hs implies no pending config, so this never races the apply above.
        if (w_hs && w_legal) begin
          w_nxt_pend   = 1'b1;
          w_nxt_pend_n = cfg_n;
          w_nxt_pend_m = cfg_m;
        end
      end

      S_SETTLE: begin
        w_nxt_n_cnt = '0;
        w_nxt_m_cnt = '0;
        if (r_set_cnt == c_SET_LAST) begin
          w_nxt_set   = '0;
          w_nxt_state = enable ? S_RUN : S_IDLE;
        end else begin
          w_nxt_set = r_set_cnt + 1'b1;
        end
      end

      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_n_cnt = '0;
        w_nxt_m_cnt = '0;
        w_nxt_set   = '0;
      end
    endcase
  end

  assign w_nxt_n = w_apply ? w_apply_n : r_n;
  assign w_nxt_m = w_apply ? w_apply_m : r_m;

  // Strobes are decoded from the next counter values so they line up with them.
  assign w_nxt_n_end = (w_nxt_state == S_RUN) && (w_nxt_n_cnt == w_nxt_n - 1'b1);
  assign w_nxt_div_m = w_nxt_n_end && (w_nxt_m_cnt == w_nxt_m - 1'b1);

  always_comb begin
    w_nxt_lock_cnt = r_lock_cnt;
    if (w_nxt_state != S_RUN) begin
      w_nxt_lock_cnt = '0;
    end else if (w_nxt_div_m && (r_lock_cnt != c_LCK_MAX)) begin
      w_nxt_lock_cnt = r_lock_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_n_cnt    <= '0;
      r_m_cnt    <= '0;
      r_n        <= N_W'(DEF_N);
      r_m        <= M_W'(DEF_M);
      r_pend     <= 1'b0;
      r_pend_n   <= '0;
      r_pend_m   <= '0;
      r_set_cnt  <= '0;
      r_lock_cnt <= '0;
      r_div_n    <= 1'b1;
      r_div_m    <= 1'b0;
      r_lock     <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_n_cnt    <= w_nxt_n_cnt;
      r_m_cnt    <= w_nxt_m_cnt;
      r_n        <= w_nxt_n;
      r_m        <= w_nxt_m;
      r_pend     <= w_nxt_pend;
      r_pend_n   <= w_nxt_pend_n;
      r_pend_m   <= w_nxt_pend_m;
      r_set_cnt  <= w_nxt_set;
      r_lock_cnt <= w_nxt_lock_cnt;
      r_div_n    <= !w_nxt_n_end;
      r_div_m    <= w_nxt_div_m;
      r_lock     <= (w_nxt_lock_cnt == c_LCK_MAX);
      r_busy     <= (w_nxt_state != S_IDLE);
      r_ready    <= (w_nxt_state != S_SETTLE) && !w_nxt_pend;
      r_cfg_err  <= w_hs && !w_legal;
    end
  end

  assign DIV_N     = r_div_n;
  assign DIV_M     = r_div_m;
  assign M         = r_m;
  assign M_counter = r_m_cnt;
  assign lock      = r_lock;
  assign busy      = r_busy;
  assign cfg_ready = r_ready;
  assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_fmdll_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmdll_div_sequencer
// Brief    : Scoreboard bench: a frame-position model queues expected outputs
//            per cycle, a monitor compares them; directed spot checks added.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fmdll_div_sequencer;
  localparam int N_W = 4, M_W = 2, DEF_N = 4, DEF_M = 2;
  localparam int SETTLE_CYC = 2, LOCK_FRAMES = 16;

  logic           clk_out = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic           cfg_valid = 1'b0;
  logic [N_W-1:0] cfg_n = '0;
  logic [M_W-1:0] cfg_m = '0;
  logic           cfg_ready, cfg_err, DIV_N, DIV_M, lock, busy;
  logic [M_W-1:0] M, M_counter;

  always #5 clk_out = ~clk_out;

  fmdll_div_sequencer #(
    .N_W(N_W), .M_W(M_W), .DEF_N(DEF_N), .DEF_M(DEF_M),
    .SETTLE_CYC(SETTLE_CYC), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk_out(clk_out), .rst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .DIV_N(DIV_N), .DIV_M(DIV_M), .M(M), .M_counter(M_counter),
    .lock(lock), .busy(busy)
  );

  typedef struct packed {
    logic           div_n;
    logic           div_m;
    logic [M_W-1:0] m;
    logic [M_W-1:0] mc;
    logic           lock;
    logic           busy;
    logic           ready;
    logic           err;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int   checks = 0;
  int   failures = 0;

  // Model: state (0 idle, 1 run, 2 settle) and position inside the N*M frame.
  int mst, mpos, mn, mm, mset, mframes, mpn, mpm;
  bit mpend, merr;

  function automatic void model_reset();
    mst = 0; mpos = 0; mn = DEF_N; mm = DEF_M; mset = 0; mframes = 0;
    mpend = 0; mpn = 0; mpm = 0; merr = 0;
  endfunction

  function automatic void model_apply(input int n, input int m);
    mn = n; mm = m; mst = 2; mset = 0; mpos = 0;
  endfunction

  function automatic void model_step();
    bit hs, legal;
    hs    = cfg_valid && (mst != 2) && !mpend;
    legal = (int'(cfg_n) >= 2) && (int'(cfg_m) >= 1);
    merr  = hs && !legal;
    case (mst)
      0: begin
        if (mpend) begin model_apply(mpn, mpm); mpend = 0; end
        else if (hs && legal) model_apply(int'(cfg_n), int'(cfg_m));
        else if (enable) begin mst = 1; mpos = 0; end
      end
      1: begin
        if (mpos == mn * mm - 1) begin
          if (mpend) begin model_apply(mpn, mpm); mpend = 0; end
          else if (!enable) mst = 0;
          else mpos = 0;
        end else begin
          mpos++;
        end
        if (hs && legal) begin mpend = 1; mpn = int'(cfg_n); mpm = int'(cfg_m); end
      end
      default: begin
        if (mset == SETTLE_CYC - 1) begin mst = enable ? 1 : 0; mpos = 0; end
        else mset++;
      end
    endcase
    if (mst != 1) mframes = 0;
    else if (mpos == mn * mm - 1 && mframes < LOCK_FRAMES) mframes++;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    bit   run;
    run     = (mst == 1);
    o.div_n = !(run && (mpos % mn) == mn - 1);
    o.div_m = run && (mpos == mn * mm - 1);
    o.m     = M_W'(mm);
    o.mc    = run ? M_W'(mpos / mn) : '0;
    o.lock  = (mframes >= LOCK_FRAMES);
    o.busy  = (mst != 0);
    o.ready = (mst != 2) && !mpend;
    o.err   = merr;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk_out);
    if (!rst_n) model_reset();
    else model_step();
    exp_q.push_back(model_obs());
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk_out);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          mon_a = {DIV_N, DIV_M, M, M_counter, lock, busy, cfg_ready, cfg_err};
          checks++;
          if (mon_a !== mon_e) begin
            failures++;
            $display("FAIL scoreboard t=%0t got=%b exp=%b (div_n div_m m mc lock busy ready err)",
                     $time, mon_a, mon_e);
          end
        end
      end
    join_none

    model_reset();
    tick(); tick();
    check("rst_div_n", DIV_N, 1);  check("rst_div_m", DIV_M, 0);
    check("rst_m", M, DEF_M);      check("rst_mc", M_counter, 0);
    check("rst_lock", lock, 0);    check("rst_busy", busy, 0);
    check("rst_ready", cfg_ready, 1); check("rst_err", cfg_err, 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Default N=4, M=2 frames.
    enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("def_div_n", DIV_N, (k % 4) != 0);
      check("def_div_m", DIV_M, (k == 8) || (k == 16));
      check("def_mc", M_counter, ((k - 1) / 4) % 2);
    end

    // Mid-frame reconfiguration to N=3, M=1.
    tick(); tick();
    cfg_valid = 1'b1; cfg_n = 4'd3; cfg_m = 2'd1;
    tick();
    check("pend_ready", cfg_ready, 0);
    cfg_valid = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      tick();
      check("old_frame_div_m", DIV_M, k == 8);
    end
    tick();
    check("settle1_div_n", DIV_N, 1); check("settle1_busy", busy, 1);
    tick();
    check("settle2_div_n", DIV_N, 1); check("settle2_ready", cfg_ready, 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("n3_div_n", DIV_N, (k % 3) != 0);
      check("n3_div_m", DIV_M, (k % 3) == 0);
      check("n3_m", M, 1);
      check("n3_mc", M_counter, 0);
    end

    // Handshake in the boundary cycle: next frame still uses N=3.
    cfg_valid = 1'b1; cfg_n = 4'd2; cfg_m = 2'd1;
    tick();
    check("bnd_div_n", DIV_N, 1); check("bnd_ready", cfg_ready, 0);
    cfg_valid = 1'b0;
    tick();
    tick();
    check("bnd_old_div_m", DIV_M, 1);
    tick(); tick();

    // 16 clean N=2, M=1 frames -> lock.
    for (int k = 1; k <= 32; k++) begin
      tick();
      check("n2_div_n", DIV_N, (k % 2) != 0);
      check("n2_lock", lock, k >= 32);
    end

    // Illegal configs: error pulse only.
    cfg_valid = 1'b1; cfg_n = 4'd1; cfg_m = 2'd1;
    tick();
    check("ill_n_err", cfg_err, 1); check("ill_n_lock", lock, 1);
    cfg_n = 4'd5; cfg_m = 2'd0;
    tick();
    check("ill_m_err", cfg_err, 1); check("ill_m_m", M, 1);
    cfg_valid = 1'b0;
    tick();
    check("ill_err_clear", cfg_err, 0); check("ill_lock", lock, 1);
    check("ill_m", M, 1);

    // Legal config clears lock on SETTLE entry.
    cfg_valid = 1'b1; cfg_n = 4'd4; cfg_m = 2'd2;
    tick();
    cfg_valid = 1'b0;
    tick();
    check("cfg_lock_clear", lock, 0); check("cfg_settle_busy", busy, 1);
    check("cfg_m_applied", M, 2);
    tick();
    tick();

    // Enable dropped at RUN cycle 5 of an N=4, M=2 frame.
    tick(); tick(); tick(); tick();
    enable = 1'b0;
    tick(); tick(); tick();
    check("drop_div_m", DIV_M, 1); check("drop_div_n", DIV_N, 0);
    check("drop_busy", busy, 1);
    tick();
    check("drop_idle_busy", busy, 0); check("drop_idle_div_n", DIV_N, 1);
    tick();

    // Asynchronous reset with a pending config.
    enable = 1'b1;
    tick(); tick();
    cfg_valid = 1'b1; cfg_n = 4'd3; cfg_m = 2'd3;
    tick();
    check("ar_pend_ready", cfg_ready, 0);
    cfg_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    exp_q.push_back(model_obs());
    #1;
    check("ar_div_n", DIV_N, 1); check("ar_div_m", DIV_M, 0);
    check("ar_m", M, DEF_M);     check("ar_lock", lock, 0);
    check("ar_ready", cfg_ready, 1); check("ar_busy", busy, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("post_rst_m", M, DEF_M);
      check("post_rst_div_m", DIV_M, k == 8);
    end

    tick();
    @(negedge clk_out);
    #1;
    check("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
